// File: rtl/rtl_one_chk.sv
// Receive-side checker for the byte-plus-offset-parity link: realigns each byte with its late
// parity bit, flags and counts mismatches, and tracks link lock. Optional macro RTL_ONE_CHK_DOUT_EN.
module rtl_one_chk #(
  parameter logic [7:0] OFFSET   = 8'h55,
  parameter int         PAR_LAT  = 3,
  parameter int         CNT_W    = 16,
  parameter int         LOCK_N   = 4,
  parameter int         UNLOCK_N = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       data_in,
  input  logic             vld_in,
  input  logic             par_in,
  input  logic             clr,
  output logic             err_pulse,
  output logic             chk_vld,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_cnt,
  output logic             locked
`ifdef RTL_ONE_CHK_DOUT_EN
  ,
  output logic [7:0]       dout,
  output logic             dout_vld
`endif
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [3:0]       LOCK_RUN   = 4'(LOCK_N);
  localparam logic [3:0]       UNLOCK_RUN = 4'(UNLOCK_N);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  // Carry out of the offset addition is dropped before the XOR reduction.
  function automatic logic exp_parity(input logic [7:0] d);
    logic [7:0] sum;
    sum = d + OFFSET;
    return ^sum;
  endfunction

  logic [7:0] data_pipe_r [PAR_LAT];
  logic       vld_pipe_r  [PAR_LAT];
  state_t     state_r;
  state_t     state_nxt_s;
  logic [3:0] run_r;
  logic [3:0] run_nxt_s;
  logic [7:0] tail_data_s;
  logic       tail_vld_s;
  logic       mismatch_s;
  logic       match_s;

  assign tail_data_s = data_pipe_r[PAR_LAT-1];
  assign tail_vld_s  = vld_pipe_r[PAR_LAT-1];
  assign mismatch_s  = tail_vld_s & (exp_parity(tail_data_s) != par_in);
  assign match_s     = tail_vld_s & ~mismatch_s;

  // Alignment delay line, advancing every cycle so byte and parity meet at the tail.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PAR_LAT; i++) begin
        data_pipe_r[i] <= 8'h00;
        vld_pipe_r[i]  <= 1'b0;
      end
    end else begin
      data_pipe_r[0] <= data_in;
      vld_pipe_r[0]  <= vld_in;
      for (int i = 1; i < PAR_LAT; i++) begin
        data_pipe_r[i] <= data_pipe_r[i-1];
        vld_pipe_r[i]  <= vld_pipe_r[i-1];
      end
    end
  end

  // Lock FSM next-state: run counts matches in HUNT and mismatches in LOCKED.
  always_comb begin
    state_nxt_s = state_r;
    run_nxt_s   = run_r;
    if (tail_vld_s) begin
      case (state_r)
        HUNT: begin
          if (match_s) begin
            if (run_r + 4'd1 == LOCK_RUN) begin
              state_nxt_s = LOCKED;
              run_nxt_s   = 4'd0;
            end else begin
              run_nxt_s = run_r + 4'd1;
            end
          end else begin
            run_nxt_s = 4'd0;
          end
        end
        LOCKED: begin
          if (mismatch_s) begin
            if (run_r + 4'd1 == UNLOCK_RUN) begin
              state_nxt_s = HUNT;
              run_nxt_s   = 4'd0;
            end else begin
              run_nxt_s = run_r + 4'd1;
            end
          end else begin
            run_nxt_s = 4'd0;
          end
        end
        default: begin
          state_nxt_s = HUNT;
          run_nxt_s   = 4'd0;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
      run_nxt_s   = run_r;
    end
  end

  // Lock FSM state and run counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= HUNT;
      run_r   <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      run_r   <= run_nxt_s;
    end
  end

  // Registered check results; clr beats a coincident mismatch for the count and sticky flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chk_vld    <= 1'b0;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      err_cnt    <= {CNT_W{1'b0}};
      locked     <= 1'b0;
    end else begin
      chk_vld   <= tail_vld_s;
      err_pulse <= mismatch_s;
      locked    <= (state_nxt_s == LOCKED);
      if (clr) begin
        err_sticky <= 1'b0;
        err_cnt    <= {CNT_W{1'b0}};
      end else if (mismatch_s) begin
        err_sticky <= 1'b1;
        if (err_cnt != CNT_MAX) begin
          err_cnt <= err_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

`ifdef RTL_ONE_CHK_DOUT_EN
  // Forward the realigned byte; only parity-clean bytes are marked valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout     <= 8'h00;
      dout_vld <= 1'b0;
    end else begin
      dout_vld <= match_s;
      if (tail_vld_s) begin
        dout <= tail_data_s;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rtl_one_chk.sv
// Directed, table-driven bench for rtl_one_chk (PAR_LAT=3, CNT_W=4, LOCK_N=4, UNLOCK_N=2).
module tb_rtl_one_chk;

  localparam int NV = 31;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       vld_in;
  logic       par_in;
  logic       clr;
  logic       err_pulse;
  logic       chk_vld;
  logic       err_sticky;
  logic [3:0] err_cnt;
  logic       locked;
`ifdef RTL_ONE_CHK_DOUT_EN
  logic [7:0] dout;
  logic       dout_vld;
`endif

  rtl_one_chk #(
    .OFFSET  (8'h55),
    .PAR_LAT (3),
    .CNT_W   (4),
    .LOCK_N  (4),
    .UNLOCK_N(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .vld_in    (vld_in),
    .par_in    (par_in),
    .clr       (clr),
    .err_pulse (err_pulse),
    .chk_vld   (chk_vld),
    .err_sticky(err_sticky),
    .err_cnt   (err_cnt),
    .locked    (locked)
`ifdef RTL_ONE_CHK_DOUT_EN
    ,
    .dout      (dout),
    .dout_vld  (dout_vld)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       clr;
    logic       exp_err;
    logic [3:0] exp_cnt;
    logic       exp_sticky;
    logic       exp_locked;
  } vec_t;

  vec_t vecs [NV];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [7:0] outs();
    return {chk_vld, err_pulse, err_sticky, locked, err_cnt};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h ({chk,err,sticky,locked,cnt})", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [7:0] d, input logic p, input logic c,
                         input logic e, input logic [3:0] n, input logic s, input logic l);
    vecs[i] = '{d, p, c, e, n, s, l};
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic p, input logic c);
    vld_in  = v;
    data_in = d;
    par_in  = p;
    clr     = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic quiet;
    // Parities of (d + 0x55): 02->1 00->0 01->0 FF->1 AB->0 10->0 3C->1 80->1
    set_vec(0, 8'h02, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    set_vec(1, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    set_vec(2, 8'h01, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    set_vec(3, 8'hFF, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    set_vec(4, 8'hAB, 1'b1, 1'b0, 1'b1, 4'd1, 1'b1, 1'b1);
    set_vec(5, 8'h10, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b1);
    set_vec(6, 8'h3C, 1'b0, 1'b0, 1'b1, 4'd2, 1'b1, 1'b1);
    set_vec(7, 8'h80, 1'b0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0);
    set_vec(8, 8'h02, 1'b0, 1'b0, 1'b1, 4'd4, 1'b1, 1'b0);
    for (int i = 9; i < 29; i++) begin
      set_vec(i, 8'h00, 1'b1, 1'b0, 1'b1, ((i - 4) > 15) ? 4'd15 : 4'(i - 4), 1'b1, 1'b0);
    end
    set_vec(29, 8'h00, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
    set_vec(30, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

    rst = 1'b0;
    vld_in = 1'b0; data_in = 8'h00; par_in = 1'b0; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", outs(), 8'h00);
    rst = 1'b1;

    // Streaming table: byte c enters at cycle c, its parity (and clr) at c+3, result at c+4.
    for (int c = 0; c < NV + 4; c++) begin
      @(posedge clk);
      #1;
      if (c >= 4) begin
        check($sformatf("vec%0d", c - 4), outs(),
              {1'b1, vecs[c-4].exp_err, vecs[c-4].exp_sticky, vecs[c-4].exp_locked, vecs[c-4].exp_cnt});
      end else begin
        check($sformatf("idle%0d", c), outs(), 8'h00);
      end
      vld_in  = (c < NV);
      data_in = (c < NV) ? vecs[c].data : 8'h00;
      if (c >= 3 && c - 3 < NV) begin
        par_in = vecs[c-3].par;
        clr    = vecs[c-3].clr;
      end else begin
        par_in = 1'b0;
        clr    = 1'b0;
      end
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("drained", outs(), 8'h00);

    // Gap pattern 1,0,1; the parity slot of the empty cycle carries a 1 that must be ignored.
    drive(1'b1, 8'h02, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 8'hAB, 1'b0, 1'b0);
    check("gap_c3", outs(), 8'h00);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check("gap_c4", outs(), {1'b1, 1'b0, 1'b0, 1'b0, 4'd0});
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check("gap_c5", outs(), 8'h00);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check("gap_c6", outs(), {1'b1, 1'b1, 1'b1, 1'b0, 4'd1});
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("gap_c7", outs(), {1'b0, 1'b0, 1'b1, 1'b0, 4'd1});

    // Reset between a byte and its parity: immediate clear, and the byte is never checked.
    drive(1'b1, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    check("reset_async", outs(), 8'h00);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b1;
    quiet = 1'b1;
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 8'h00, (k == 0) ? 1'b1 : 1'b0, 1'b0);
      if (chk_vld !== 1'b0 || err_pulse !== 1'b0) quiet = 1'b0;
    end
    check("no_chk_after_reset", {7'd0, quiet}, 8'h01);

    // Isolated byte 01 with good parity, then the same byte with bad parity.
    drive(1'b1, 8'h01, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("iso_match", outs(), {1'b1, 1'b0, 1'b0, 1'b0, 4'd0});
`ifdef RTL_ONE_CHK_DOUT_EN
    check("dout_match", dout, 8'h01);
    check("dout_vld_match", {7'd0, dout_vld}, 8'h01);
`endif
    drive(1'b1, 8'h01, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check("iso_mismatch", outs(), {1'b1, 1'b1, 1'b1, 1'b0, 4'd1});
`ifdef RTL_ONE_CHK_DOUT_EN
    check("dout_vld_mismatch", {7'd0, dout_vld}, 8'h00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rtl_one_chk.md
Name: rtl_one_chk

Overview:
- Receive-side checker for the byte-plus-offset-parity link.
- The transmit side registers a byte, adds constant 0x55 (mod 256), XOR-reduces the 8-bit sum, and delivers that parity bit a fixed number of cycles later.
- This block realigns the original byte with the arriving parity bit, recomputes the expected parity and flags mismatches.
- It also counts errors and runs a lock/unlock state machine on consecutive-result runs.

Parameters:
- OFFSET, 8'h55, constant added to the byte before the parity XOR.
- PAR_LAT, 3, cycles between the byte being sampled (vld_in high) and its parity bit being sampled on par_in; legal range 1..8.
- CNT_W, 16, width of the saturating error counter.
- LOCK_N, 4, consecutive matches required to enter LOCKED (1..15).
- UNLOCK_N, 2, consecutive mismatches required to drop from LOCKED to HUNT (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset. One clock; reset is asynchronous and active-low.
- data_in  in  8  byte presented to the transmit side.
- vld_in  in  1  data_in valid this cycle.
- par_in  in  1  parity bit from the transmit side, for the byte sampled PAR_LAT cycles earlier.
- clr  in  1  synchronous clear of err_cnt and err_sticky.
- err_pulse  out  1  one-cycle pulse per mismatching checked byte.
- chk_vld  out  1  one-cycle pulse per checked byte, match or mismatch.
- err_sticky  out  1  set on any mismatch, held until clr.
- err_cnt  out  CNT_W  saturating mismatch count.
- locked  out  1  lock FSM is in LOCKED.

Behaviour:
- Reset (rst=0, asynchronous): all pipeline stages, err_pulse, chk_vld, err_sticky, err_cnt, run counter and locked go to 0; FSM enters HUNT.
- Alignment: data_in and vld_in enter a PAR_LAT-deep shift register, advancing every cycle regardless of valid.
- At the register tail, expected parity = XOR reduction of (tail_data + OFFSET) truncated to 8 bits. Carry out of bit 7 is discarded.
- Compare: when tail valid=1, compare expected parity with par_in sampled in that same cycle.
  - Results are registered, so chk_vld and err_pulse are high in cycle t+PAR_LAT+1 for a byte with vld_in in cycle t.
  - Back-to-back vld_in yields back-to-back chk_vld; throughput is 1 byte/cycle.
- When tail valid=0, par_in is ignored, no pulses are produced, and FSM and run counters hold.
- err_cnt: increments by 1 per mismatch; saturates at 2^CNT_W-1 (no wrap).
- err_sticky: set on mismatch.
- clr: in the cycle it is sampled, err_cnt goes to 0 and err_sticky to 0.
  - clr wins over a simultaneous mismatch; that mismatch is not counted.
  - err_pulse still fires for that mismatch.
  - clr does not affect the FSM.
- Lock FSM (evaluated on checked bytes only; run counter 4 bits):
  - HUNT: a match increments the run, a mismatch zeroes it. When the run reaches LOCK_N, go to LOCKED and zero the run.
  - LOCKED: a mismatch increments the run, a match zeroes it. When the run reaches UNLOCK_N, go to HUNT and zero the run.
  - locked is registered and equals (state==LOCKED).
  - It updates in the same cycle as the chk_vld of the deciding byte.
- Reset mid-stream: all in-flight bytes are discarded, and no check fires for them after reset release.
  - Bytes with vld_in before reset whose parity arrives after reset are never checked.

Optional Feature:
- Macro: RTL_ONE_CHK_DOUT_EN.
- Defined: adds ports dout (out, 8) and dout_vld (out, 1).
  - dout carries the realigned byte, registered alongside chk_vld, with the same timing.
  - dout_vld equals chk_vld AND match, so only bytes whose parity checks are forwarded.
  - Both ports reset to 0.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Reset release, PAR_LAT=3: vld_in=1 with data_in=8'h02 (sum 8'h57, parity 1) at cycle 0; par_in=1 at cycle 3 -> chk_vld=1, err_pulse=0 at cycle 4; err_cnt=0.
- Wrap-around: data_in=8'hAB (sum 8'h00, parity 0), par_in=1 -> err_pulse=1 at t+4, err_sticky=1, err_cnt=1.
- Lock/unlock, LOCK_N=4, UNLOCK_N=2: four matching bytes, then two mismatching -> locked rises with the 4th chk_vld and falls with the 6th. A match between two mismatches keeps locked=1.
- Saturation, CNT_W=4: 20 consecutive mismatches -> err_cnt stops at 4'hF. Then clr coincident with a mismatch -> err_cnt=0, err_sticky=0, err_pulse=1.
- Gaps and reset: vld_in pattern 1,0,1 -> exactly two chk_vld pulses at the aligned cycles. Assert rst=0 between a byte's vld_in and its par_in -> no chk_vld for that byte, all outputs 0 immediately.
- With RTL_ONE_CHK_DOUT_EN: data_in=8'h01 (sum 8'h56, parity 0), par_in=0 -> dout=8'h01, dout_vld=1 at t+4. Same byte with par_in=1 -> dout_vld=0.
